// File: rtl/as_serial_pipe.sv
// as_serial_pipe: digit-serial signed add/sub, DIGIT bits per cycle LSB-first, valid/ready on both sides
//   Ports: clk, rst_n (async active-low), in_valid/in_ready, sel (0 add, 1 sub), A, B,
//          out_valid/out_ready, S (result), C (carry out of MSB), O (signed overflow).
//   Optional: define AS_SERIAL_SATURATE_EN to clamp S on overflow (C/O stay raw).
module as_serial_pipe #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             O
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = NDIG > 1 ? $clog2(NDIG) : 1;
    if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_param
        $error("as_serial_pipe: WIDTH must be a positive multiple of DIGIT");
    end
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, acc, res, res_out;
    logic             carry, cin_msb, ovf;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    assign in_ready = state == IDLE;
    always_comb begin
        dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        res     = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        // carry into the digit's top bit recovered from the sum bit: a ^ b ^ s
        cin_msb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
        ovf     = cin_msb ^ dsum[DIGIT];
`ifdef AS_SERIAL_SATURATE_EN
        // on overflow the raw carry out is the sign of the true result
        res_out = ovf ? (dsum[DIGIT] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : res;
`else
        res_out = res;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            S         <= '0;
            C         <= 1'b0;
            O         <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_sh  <= A;
                b_sh  <= sel ? ~B : B;
                carry <= sel;
                cnt   <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            acc   <= res;
            carry <= dsum[DIGIT];
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(NDIG - 1)) begin
                S         <= res_out;
                C         <= dsum[DIGIT];
                O         <= ovf;
                out_valid <= 1'b1;
                state     <= DONE;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule

// File: tb/tb_as_serial_pipe.sv
// tb_as_serial_pipe: table, corner-sequence and random checks of as_serial_pipe (WIDTH=16, DIGIT=4)
module tb_as_serial_pipe;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             sel = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] S;
    logic             C;
    logic             O;

    int tests = 0;
    int fails = 0;

    as_serial_pipe #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .S(S), .C(C), .O(O)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] s, input logic c, input logic o);
`ifdef AS_SERIAL_SATURATE_EN
        return o ? (c ? 16'h8000 : 16'h7FFF) : s;
`else
        return s;
`endif
    endfunction

    // reference: true integer result, then wrap/flag from its range
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] es, output logic ec, output logic eo);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = s ? sa - sb : sa + sb;
        eo = (r > 32767) || (r < -32768);
        ec = s ? (int'(a) >= int'(b)) : (int'(a) + int'(b) >= 65536);
        es = sat(r[15:0], ec, eo);
    endtask

    // accept one op and wait for the result; checks latency and that S holds during RUN
    task automatic start_wait(input logic [15:0] a, input logic [15:0] b, input logic s);
        int lat;
        logic [15:0] prev;
        @(negedge clk);
        prev = S;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        A = a;
        B = b;
        sel = s;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        sel = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat == 2) check("s_hold_run", 32'(S), 32'(prev));
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(NDIG));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic s, input logic [15:0] es, input logic ec, input logic eo);
        start_wait(a, b, s);
        check({tag, "_S"}, 32'(S), 32'(es));
        check({tag, "_C"}, 32'(C), 32'(ec));
        check({tag, "_O"}, 32'(O), 32'(eo));
        handshake();
    endtask

    initial begin
        vec_t vt[8];
        logic [15:0] es, hs;
        logic ec, eo, hc, ho;
        vt[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vt[1] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_S", 32'(S), 32'd0);
        check("rst_C", 32'(C), 32'd0);
        check("rst_O", 32'(O), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].s,
                      sat(vt[i].es, vt[i].ec, vt[i].eo), vt[i].ec, vt[i].eo);

        // result held under back-pressure; in_valid pulses are ignored
        start_wait(16'h1234, 16'h0FFF, 1'b0);
        hs = S;
        hc = C;
        ho = O;
        check("bp_S", 32'(hs), 32'h2233);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            A = 16'h0001;
            B = 16'h0001;
            @(negedge clk);
            check("bp_hold_S", 32'(S), 32'(hs));
            check("bp_hold_CO", {30'd0, C, O}, {30'd0, hc, ho});
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        handshake();
        @(negedge clk);
        check("bp_no_new_op", 32'(out_valid), 32'd0);

        // reset while digit 2 is being processed
        @(negedge clk);
        in_valid = 1'b1;
        A = 16'h7FFF;
        B = 16'h0001;
        sel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_S", 32'(S), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after_rst", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic rs;
            ra = $urandom;
            rb = (i % 4 == 0) ? 16'h8000 ^ ra : 16'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, es, ec, eo);
            run_check($sformatf("rnd%0d", i), ra, rb, rs, es, ec, eo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
